// File: rtl/local_mem_traffic_engine_avalon_if.sv
// Avalon-MM master/slave bundle used by the local memory traffic engine.
interface local_mem_traffic_engine_avalon_if #(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0]      avm_address;
  logic [BURST_CNT_WIDTH-1:0] avm_burstcount;
  logic                       avm_read;
  logic                       avm_write;
  logic [DATA_WIDTH-1:0]      avm_writedata;
  logic [DATA_WIDTH/8-1:0]    avm_byteenable;
  logic                       avm_waitrequest;
  logic [DATA_WIDTH-1:0]      avm_readdata;
  logic                       avm_readdatavalid;
  logic [1:0]                 avm_response;

  modport master (
    output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, avm_response
  );

  modport slave (
    input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, avm_response
  );
endinterface

// File: rtl/local_mem_traffic_engine_avalon.sv
// Per-bank Avalon-MM traffic engine: seeded burst writes, bounded burst reads,
// optional read-back checking, and beat/error/cycle statistics.
module local_mem_traffic_engine_avalon #(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned MAX_RD_BURSTS   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_start,
  input  logic                       cfg_stop,
  input  logic [1:0]                 cfg_mode,
  input  logic [ADDR_WIDTH-1:0]      cfg_base_addr,
  input  logic [31:0]                cfg_num_bursts,
  input  logic [BURST_CNT_WIDTH-1:0] cfg_burstcount,
  input  logic [31:0]                cfg_seed,
  output logic                       status_busy,
  output logic                       status_done,
  output logic [31:0]                wr_beats,
  output logic [31:0]                rd_beats,
  output logic [31:0]                rd_err_cnt,
  output logic [63:0]                cycle_cnt,
  local_mem_traffic_engine_avalon_if.master avm
);

  localparam int unsigned LANES = DATA_WIDTH / 32;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OUT_W = $clog2(MAX_RD_BURSTS + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  logic [1:0]                 r_mode;
  logic [ADDR_WIDTH-1:0]      r_base;
  logic [31:0]                r_num;
  logic [BURST_CNT_WIDTH-1:0] r_bc;
  logic [31:0]                r_seed;
  logic                       r_stop_req;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic                       r_read;
  logic                       r_write;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [BE_W-1:0]            r_be;
  logic [31:0]                r_burst_idx;
  logic [BURST_CNT_WIDTH-1:0] r_wr_beat;
  logic [31:0]                r_wr_k;
  logic                       r_busy;
  logic                       r_done;
  logic [OUT_W-1:0]           r_outstanding;
  logic [BURST_CNT_WIDTH-1:0] r_ret_beat;
  logic [31:0]                r_ret_k;
  logic [31:0]                r_wr_beats;
  logic [31:0]                r_rd_beats;
  logic [31:0]                r_rd_err;
  logic [63:0]                r_cycles;

  logic                       w_start_ok;
  logic                       w_wr_acc;
  logic                       w_rd_acc;
  logic                       w_ret_beat;
  logic                       w_ret_last;
  logic                       w_stop;
  logic                       w_last_burst;
  logic                       w_wr_burst_end;
  logic [OUT_W-1:0]           w_out_next;
  logic [BURST_CNT_WIDTH-1:0] w_bc_cfg;
  logic [31:0]                w_exp_word;
  logic [31:0]                w_wr_word_next;
  logic [DATA_WIDTH-1:0]      w_exp_data;
  logic                       w_beat_err;

  // Handshake qualifiers and next-value helpers shared by both register blocks
  always_comb begin
    w_start_ok     = cfg_start && (cfg_mode != 2'd3);
    w_wr_acc       = r_write && !avm.avm_waitrequest;
    w_rd_acc       = r_read && !avm.avm_waitrequest;
    w_ret_beat     = avm.avm_readdatavalid && ((r_state == S_RD) || (r_state == S_DRAIN));
    w_ret_last     = w_ret_beat && (r_ret_beat == (r_bc - BURST_CNT_WIDTH'(1)));
    w_stop         = r_stop_req || cfg_stop;
    w_last_burst   = (r_burst_idx == (r_num - 32'd1));
    w_wr_burst_end = w_wr_acc && (r_wr_beat == (r_bc - BURST_CNT_WIDTH'(1)));
    w_out_next     = r_outstanding + OUT_W'(w_rd_acc) - OUT_W'(w_ret_last);
    w_bc_cfg       = (cfg_burstcount == '0) ? BURST_CNT_WIDTH'(1) : cfg_burstcount;
    w_exp_word     = r_seed + r_ret_k;
    w_wr_word_next = r_seed + r_wr_k + 32'd1;
    w_exp_data     = {LANES{w_exp_word}};
    w_beat_err     = w_ret_beat &&
                     ((avm.avm_response != 2'b00) ||
                      ((r_mode == 2'd2) && (avm.avm_readdata != w_exp_data)));
  end

  // Sequencer: phase transitions, command issue and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_base      <= '0;
      r_num       <= '0;
      r_bc        <= '0;
      r_seed      <= '0;
      r_stop_req  <= 1'b0;
      r_addr      <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_burst_idx <= '0;
      r_wr_beat   <= '0;
      r_wr_k      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_be   <= '1;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_mode      <= cfg_mode;
            r_base      <= cfg_base_addr;
            r_num       <= cfg_num_bursts;
            r_bc        <= w_bc_cfg;
            r_seed      <= cfg_seed;
            r_stop_req  <= 1'b0;
            r_addr      <= cfg_base_addr;
            r_burst_idx <= '0;
            r_wr_beat   <= '0;
            r_wr_k      <= '0;
            r_busy      <= 1'b1;
            if (cfg_num_bursts == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (cfg_mode == 2'd1) begin
              r_state <= S_RD;
              r_read  <= 1'b1;
            end else begin
              r_state <= S_WR;
              r_write <= 1'b1;
              r_wdata <= {LANES{cfg_seed}};
            end
          end
        end
        S_WR: begin
          if (cfg_stop) r_stop_req <= 1'b1;
          if (w_wr_acc) begin
            r_wr_k  <= r_wr_k + 32'd1;
            r_wdata <= {LANES{w_wr_word_next}};
            r_wr_beat <= r_wr_beat + BURST_CNT_WIDTH'(1);
          end
          if (w_wr_burst_end) begin
            r_wr_beat   <= '0;
            r_burst_idx <= r_burst_idx + 32'd1;
            r_addr      <= r_addr + ADDR_WIDTH'(r_bc);
            if (w_last_burst || w_stop) begin
              r_write <= 1'b0;
              if ((r_mode == 2'd2) && !w_stop) begin
                r_state     <= S_RD;
                r_read      <= 1'b1;
                r_burst_idx <= '0;
                r_addr      <= r_base;
              end else begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_RD: begin
          if (cfg_stop) r_stop_req <= 1'b1;
          if (w_rd_acc) begin
            r_burst_idx <= r_burst_idx + 32'd1;
            r_addr      <= r_addr + ADDR_WIDTH'(r_bc);
          end
          // A read stalled by waitrequest is held until accepted, even on stop
          if (!(r_read && avm.avm_waitrequest)) begin
            if ((w_rd_acc && w_last_burst) || w_stop) begin
              r_read  <= 1'b0;
              r_state <= S_DRAIN;
            end else begin
              r_read <= (w_out_next < OUT_W'(MAX_RD_BURSTS));
            end
          end
        end
        S_DRAIN: begin
          if (r_outstanding == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking, outstanding-burst count and statistics counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      r_ret_beat    <= '0;
      r_ret_k       <= '0;
      r_wr_beats    <= '0;
      r_rd_beats    <= '0;
      r_rd_err      <= '0;
      r_cycles      <= '0;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_outstanding <= '0;
      r_ret_beat    <= '0;
      r_ret_k       <= '0;
      r_wr_beats    <= '0;
      r_rd_beats    <= '0;
      r_rd_err      <= '0;
      r_cycles      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_wr_acc) r_wr_beats <= r_wr_beats + 32'd1;
      if (w_ret_beat) begin
        r_rd_beats <= r_rd_beats + 32'd1;
        r_ret_k    <= r_ret_k + 32'd1;
        r_ret_beat <= w_ret_last ? '0 : (r_ret_beat + BURST_CNT_WIDTH'(1));
      end
      if (w_beat_err && (r_rd_err != 32'hFFFF_FFFF)) r_rd_err <= r_rd_err + 32'd1;
      if (r_busy) r_cycles <= r_cycles + 64'd1;
    end
  end

  assign status_busy        = r_busy;
  assign status_done        = r_done;
  assign wr_beats           = r_wr_beats;
  assign rd_beats           = r_rd_beats;
  assign rd_err_cnt         = r_rd_err;
  assign cycle_cnt          = r_cycles;
  assign avm.avm_address    = r_addr;
  assign avm.avm_burstcount = r_bc;
  assign avm.avm_read       = r_read;
  assign avm.avm_write      = r_write;
  assign avm.avm_writedata  = r_wdata;
  assign avm.avm_byteenable = r_be;

endmodule
